// File: rtl/me_search_scheduler.sv
// rtl/me_search_scheduler.sv - frame-level motion-estimation block scheduler with min-SAD tracking
module me_search_scheduler #(
  parameter int NUM_BLOCKS = 16,
  parameter int SAD_W      = 16,
  parameter int MV_W       = 7,
  parameter int START_TO   = 16,
  parameter int ACC_TO     = 8192,
  localparam int BLK_W     = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             frame_start,
  input  logic [1:0]       r_in,
  output logic             go,
  output logic [1:0]       r,
  input  logic             start,
  input  logic             sad_valid,
  input  logic [SAD_W-1:0] sad,
  input  logic [MV_W-1:0]  sad_x,
  input  logic [MV_W-1:0]  sad_y,
  input  logic             pe_done,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [BLK_W-1:0] res_blk,
  output logic [MV_W-1:0]  res_mv_x,
  output logic [MV_W-1:0]  res_mv_y,
  output logic [SAD_W-1:0] res_sad,
  output logic             res_err,
  output logic             busy,
  output logic             frame_done
);

  // Counter covers the longer of the two timeout windows.
  localparam int TO_MAX = (ACC_TO > START_TO) ? ACC_TO : START_TO;
  localparam int CNT_W  = $clog2(TO_MAX + 1);
  // Extended width so the signed range compare never overflows.
  localparam int EXT_W  = MV_W + 8;

  typedef enum logic [2:0] {
    IDLE, ISSUE, WAIT_START, ACCUM, REPORT, FRAME_DONE
  } state_t;

  state_t                   state, state_n;
  logic [BLK_W-1:0]         blk_idx;
  logic [SAD_W-1:0]         best_sad;
  logic [MV_W-1:0]          best_x, best_y;
  logic                     found, err;
  logic [CNT_W-1:0]         tcnt;

  logic                     start_to_hit, acc_to_hit, last_blk;
  logic signed [EXT_W-1:0]  x_ext, y_ext, lim_hi, lim_lo;
  logic                     legal, cand_better;

  assign start_to_hit = (tcnt == CNT_W'(START_TO - 1));
  assign acc_to_hit   = (tcnt == CNT_W'(ACC_TO - 1));
  assign last_blk     = (blk_idx == BLK_W'(NUM_BLOCKS - 1));

  assign x_ext = {{8{sad_x[MV_W-1]}}, sad_x};
  assign y_ext = {{8{sad_y[MV_W-1]}}, sad_y};

  // Search-window limits: legal displacements lie in [-(L-1), L].
  always_comb begin
    lim_hi = EXT_W'(8);
    case (r)
      2'd0: lim_hi = EXT_W'(8);
      2'd1: lim_hi = EXT_W'(16);
      2'd2: lim_hi = EXT_W'(32);
      2'd3: lim_hi = EXT_W'(48);
      default: lim_hi = EXT_W'(8);
    endcase
    lim_lo = -(lim_hi - EXT_W'(1));
  end

  assign legal = (x_ext >= lim_lo) && (x_ext <= lim_hi) &&
                 (y_ext >= lim_lo) && (y_ext <= lim_hi);
  // Strict less-than so ties keep the earlier candidate.
  assign cand_better = sad_valid && legal && (sad < best_sad);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // Next-state and state-decoded control outputs.
  always_comb begin
    state_n    = state;
    go         = 1'b0;
    busy       = 1'b1;
    res_valid  = 1'b0;
    frame_done = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (frame_start) state_n = ISSUE;
      end
      ISSUE: begin
        go      = 1'b1;
        state_n = WAIT_START;
      end
      WAIT_START: begin
        if (start)             state_n = ACCUM;
        else if (start_to_hit) state_n = REPORT;
      end
      ACCUM: begin
        if (pe_done || acc_to_hit) state_n = REPORT;
      end
      REPORT: begin
        res_valid = 1'b1;
        if (res_ready) state_n = last_blk ? FRAME_DONE : ISSUE;
      end
      FRAME_DONE: begin
        frame_done = 1'b1;
        state_n    = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Datapath: range latch, block index, best-candidate tracking and timeouts.
  always_ff @(posedge clk) begin
    if (reset) begin
      r        <= '0;
      blk_idx  <= '0;
      best_sad <= '0;
      best_x   <= '0;
      best_y   <= '0;
      found    <= 1'b0;
      err      <= 1'b0;
      tcnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (frame_start) begin
            r       <= r_in;
            blk_idx <= '0;
          end
        end
        ISSUE: begin
          best_sad <= '1;
          best_x   <= '0;
          best_y   <= '0;
          found    <= 1'b0;
          err      <= 1'b0;
          tcnt     <= '0;
        end
        WAIT_START: begin
          if (start)             tcnt <= '0;
          else if (start_to_hit) err  <= 1'b1;
          else                   tcnt <= tcnt + 1'b1;
        end
        ACCUM: begin
          if (cand_better) begin
            best_sad <= sad;
            best_x   <= sad_x;
            best_y   <= sad_y;
            found    <= 1'b1;
          end
          if (!pe_done) begin
            if (acc_to_hit) err  <= 1'b1;
            else            tcnt <= tcnt + 1'b1;
          end
        end
        REPORT: begin
          if (res_ready && !last_blk) blk_idx <= blk_idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign res_blk  = blk_idx;
  assign res_mv_x = best_x;
  assign res_mv_y = best_y;
  assign res_sad  = best_sad;
  assign res_err  = (state == REPORT) && (err || !found);

endmodule

// File: tb/tb_me_search_scheduler.sv
// tb/tb_me_search_scheduler.sv - directed self-checking bench for me_search_scheduler
module tb_me_search_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic        frame_start;
  logic [1:0]  r_in;
  logic        go;
  logic [1:0]  r;
  logic        start;
  logic        sad_valid;
  logic [15:0] sad;
  logic [6:0]  sad_x, sad_y;
  logic        pe_done;
  logic        res_valid;
  logic        res_ready;
  logic        res_blk;
  logic [6:0]  res_mv_x, res_mv_y;
  logic [15:0] res_sad;
  logic        res_err;
  logic        busy;
  logic        frame_done;

  int vectors = 0;
  int miscompares = 0;
  logic go_seen;

  me_search_scheduler #(
    .NUM_BLOCKS(2), .SAD_W(16), .MV_W(7), .START_TO(16), .ACC_TO(8192)
  ) dut (
    .clk(clk), .reset(reset), .frame_start(frame_start), .r_in(r_in),
    .go(go), .r(r), .start(start), .sad_valid(sad_valid), .sad(sad),
    .sad_x(sad_x), .sad_y(sad_y), .pe_done(pe_done), .res_valid(res_valid),
    .res_ready(res_ready), .res_blk(res_blk), .res_mv_x(res_mv_x),
    .res_mv_y(res_mv_y), .res_sad(res_sad), .res_err(res_err),
    .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Advance one clock; sample point is 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cand(input logic [15:0] s, input int x, input int y);
    sad_valid = 1'b1;
    sad       = s;
    sad_x     = 7'(x);
    sad_y     = 7'(y);
    step();
    sad_valid = 1'b0;
  endtask

  // From ISSUE: move through WAIT_START into ACCUM.
  task automatic enter_accum();
    step();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    reset = 1'b1; frame_start = 1'b0; r_in = 2'd0; start = 1'b0;
    sad_valid = 1'b0; sad = '0; sad_x = '0; sad_y = '0;
    pe_done = 1'b0; res_ready = 1'b0;
    step(); step();
    reset = 1'b0;
    check("rst_go", go, 0);
    check("rst_busy", busy, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_r", r, 0);
    check("rst_res_sad", res_sad, 0);
    check("rst_res_err", res_err, 0);

    // Frame 1, block 0: min-SAD with tie keeps earlier candidate.
    r_in = 2'd0; frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    check("f1_go", go, 1);
    check("f1_busy", busy, 1);
    enter_accum();
    cand(16'd500, 1, 1);
    cand(16'd300, -2, 3);
    cand(16'd300, 4, 4);
    pe_done = 1'b1; step(); pe_done = 1'b0;
    check("b0_valid", res_valid, 1);
    check("b0_sad", res_sad, 300);
    check("b0_mvx", res_mv_x, 32'h7E);
    check("b0_mvy", res_mv_y, 3);
    check("b0_err", res_err, 0);
    check("b0_blk", res_blk, 0);
    res_ready = 1'b1; step(); res_ready = 1'b0;
    check("b1_go", go, 1);
    check("b1_blk", res_blk, 1);

    // Frame 1, block 1: range legality at r=0.
    enter_accum();
    cand(16'd10, 9, 0);
    cand(16'd10, -8, 0);
    cand(16'd700, 8, -7);
    pe_done = 1'b1; step(); pe_done = 1'b0;
    check("b1_sad", res_sad, 700);
    check("b1_mvx", res_mv_x, 8);
    check("b1_mvy", res_mv_y, 32'h79);

    // Backpressure for 20 cycles with a stray frame_start.
    go_seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      frame_start = (i == 5);
      r_in = 2'd3;
      step();
      go_seen = go_seen | go;
    end
    frame_start = 1'b0;
    check("bp_no_go", go_seen, 0);
    check("bp_valid", res_valid, 1);
    check("bp_sad", res_sad, 700);
    check("bp_mvy", res_mv_y, 32'h79);
    check("bp_r", r, 0);
    res_ready = 1'b1; step(); res_ready = 1'b0;
    check("fd_pulse", frame_done, 1);
    step();
    check("fd_clear", frame_done, 0);
    check("fd_idle", busy, 0);

    // Frame 2, block 0: only illegal candidates.
    r_in = 2'd0; frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    enter_accum();
    cand(16'd10, 9, 0);
    cand(16'd20, 0, -8);
    pe_done = 1'b1; step(); pe_done = 1'b0;
    check("ill_sad", res_sad, 16'hFFFF);
    check("ill_mvx", res_mv_x, 0);
    check("ill_err", res_err, 1);
    res_ready = 1'b1; step(); res_ready = 1'b0;
    check("to_go", go, 1);

    // Frame 2, block 1: start never arrives.
    step();
    for (int i = 0; i < 15; i++) step();
    check("to_early", res_valid, 0);
    step();
    check("to_valid", res_valid, 1);
    check("to_err", res_err, 1);
    check("to_blk", res_blk, 1);
    res_ready = 1'b1; step(); res_ready = 1'b0;
    check("to_fd", frame_done, 1);
    step();

    // Frame 3 at r=3: candidate in same cycle as pe_done, boundary displacement.
    r_in = 2'd3; frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    check("f3_r", r, 3);
    enter_accum();
    cand(16'd60, 40, -40);
    sad_valid = 1'b1; sad = 16'd50; sad_x = 7'h51; sad_y = 7'h30;
    pe_done = 1'b1;
    step();
    sad_valid = 1'b0; pe_done = 1'b0;
    check("same_sad", res_sad, 50);
    check("same_mvx", res_mv_x, 32'h51);
    check("same_mvy", res_mv_y, 32'h30);
    check("same_err", res_err, 0);
    res_ready = 1'b1; step(); res_ready = 1'b0;

    // Reset during ACCUM of block 1.
    enter_accum();
    cand(16'd5, 1, 1);
    reset = 1'b1; step(); reset = 1'b0;
    check("mr_busy", busy, 0);
    check("mr_valid", res_valid, 0);
    check("mr_sad", res_sad, 0);
    check("mr_mvx", res_mv_x, 0);
    check("mr_r", r, 0);
    check("mr_blk", res_blk, 0);

    // Restart at r=1 from block 0; boundary legality at L=16.
    r_in = 2'd1; res_ready = 1'b1; frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    check("rs_go", go, 1);
    check("rs_blk", res_blk, 0);
    check("rs_r", r, 1);
    enter_accum();
    cand(16'd99, 16, -15);
    cand(16'd1, 17, 0);
    cand(16'd2, 0, -16);
    pe_done = 1'b1; step(); pe_done = 1'b0;
    check("rs_sad", res_sad, 99);
    check("rs_mvx", res_mv_x, 32'h10);
    check("rs_mvy", res_mv_y, 32'h71);
    step();
    check("rs_next_go", go, 1);
    check("rs_next_blk", res_blk, 1);
    res_ready = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
